// File: rtl/mem_io_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder_pkg
// Description : Address map and decode helper for the memory/I-O responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_io_responder_pkg;

    localparam int          RAM_ADDR_W_DEF = 17;
    localparam logic [17:0] IO_BASE        = 18'h30000;
    localparam logic [17:0] IO_UART        = 18'h30000;
    localparam logic [17:0] IO_CLK_STOP    = 18'h30004;
    localparam logic [1:0]  IO_SEL         = IO_BASE[17:16];

    // Which block answers a given 18-bit bus address.
    typedef enum logic [1:0] {
        RGN_RAM   = 2'd0,
        RGN_UART  = 2'd1,
        RGN_CLK   = 2'd2,
        RGN_OTHER = 2'd3
    } region_e;

    // 0x30004..0x30007 all land in the clock/stop window; only 0x30004
    // itself has write side effects, which the caller checks separately.
    function automatic region_e decode_region(input logic [17:0] addr);
        if (addr[17:16] != IO_SEL) begin
            return RGN_RAM;
        end
        if (addr == IO_UART) begin
            return RGN_UART;
        end
        if (addr[17:2] == IO_CLK_STOP[17:2]) begin
            return RGN_CLK;
        end
        return RGN_OTHER;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Byte-wide synchronous FIFO with same-cycle push/pop and a
//               combinational head output. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_push,
    input  wire logic          i_pop,
    input  wire logic [7:0]    i_data,
    output logic      [7:0]    o_head,
    output logic               o_full,
    output logic               o_empty,
    output logic      [CW-1:0] o_count,
    output logic               o_push_drop
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    // A pop only happens with data present; a pop at full frees the slot
    // the simultaneous push needs.
    assign w_pop       = i_pop && !o_empty;
    assign w_push      = i_push && (!o_full || w_pop);
    assign o_push_drop = i_push && o_full && !w_pop;

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Storage array, not reset: emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Responder side of the CPU byte bus: program RAM plus the
//               memory-mapped UART FIFOs, cycle counter and stop port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W  = RAM_ADDR_W_DEF,
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2
) (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    input  wire logic [31:0] mem_a_in,
    input  wire logic [7:0]  mem_wdata_in,
    input  wire logic        mem_wr_in,
    output logic      [7:0]  mem_rdata_out,
    output logic             io_buffer_full,
    output logic      [7:0]  tx_data,
    output logic             tx_valid,
    input  wire logic        tx_ready,
    input  wire logic [7:0]  rx_data,
    input  wire logic        rx_valid,
    output logic             rx_full,
    output logic             program_stop,
    output logic             tx_overflow
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]            r_ram [2**RAM_ADDR_W];
    logic [31:0]           r_cnt;
    logic [31:0]           r_snap;

    region_e               w_region;
    logic [RAM_ADDR_W-1:0] w_ram_idx;
    logic                  w_stop_wr;
    logic                  w_tx_push;
    logic [7:0]            w_tx_wdata;
    logic                  w_tx_empty;
    logic                  w_tx_drop;
    logic [TX_CW-1:0]      w_tx_count;
    logic                  w_rx_pop;
    logic [7:0]            w_rx_head;
    logic                  w_rx_empty;
    logic [RX_CW-1:0]      w_rx_count;
    logic [7:0]            w_snap_byte;
    logic                  w_unused_addr_hi;
    logic                  w_unused_tx_full;
    logic                  w_unused_rx_full;
    logic                  w_unused_rx_drop;

    assign w_unused_addr_hi = ^mem_a_in[31:18];

    assign w_region  = decode_region(mem_a_in[17:0]);
    assign w_ram_idx = mem_a_in[RAM_ADDR_W-1:0];

    // A write to the stop port also queues a NUL so the host sees the end.
    assign w_stop_wr  = mem_wr_in && (w_region == RGN_CLK) && (mem_a_in[1:0] == 2'b00);
    assign w_tx_push  = (mem_wr_in && (w_region == RGN_UART) && (mem_wdata_in != 8'h00))
                        || w_stop_wr;
    assign w_tx_wdata = w_stop_wr ? 8'h00 : mem_wdata_in;
    assign w_rx_pop   = !mem_wr_in && (w_region == RGN_UART);

    assign w_snap_byte = r_snap[{mem_a_in[1:0], 3'b000} +: 8];

    byte_fifo #(
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk         (clk_in),
        .rst         (rst_in),
        .i_push      (w_tx_push),
        .i_pop       (tx_ready),
        .i_data      (w_tx_wdata),
        .o_head      (tx_data),
        .o_full      (w_unused_tx_full),
        .o_empty     (w_tx_empty),
        .o_count     (w_tx_count),
        .o_push_drop (w_tx_drop)
    );

    byte_fifo #(
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clk         (clk_in),
        .rst         (rst_in),
        .i_push      (rx_valid),
        .i_pop       (w_rx_pop),
        .i_data      (rx_data),
        .o_head      (w_rx_head),
        .o_full      (w_unused_rx_full),
        .o_empty     (w_rx_empty),
        .o_count     (w_rx_count),
        .o_push_drop (w_unused_rx_drop)
    );

    assign tx_valid       = !w_tx_empty;
    assign rx_full        = (w_rx_count == RX_CW'(RX_DEPTH));
    // Margin leaves room for the write already in flight when the CPU stalls.
    assign io_buffer_full = (w_tx_count >= TX_CW'(TX_DEPTH - FULL_MARGIN));

    // Program RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (mem_wr_in && (w_region == RGN_RAM)) begin
            r_ram[w_ram_idx] <= mem_wdata_in;
        end
    end

    // Registered read path; reading 0x30004 latches the counter snapshot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_rdata_out <= 8'h00;
            r_snap        <= 32'h0;
        end else if (!mem_wr_in) begin
            unique case (w_region)
                RGN_RAM:  mem_rdata_out <= r_ram[w_ram_idx];
                RGN_UART: mem_rdata_out <= w_rx_empty ? 8'h00 : w_rx_head;
                RGN_CLK: begin
                    if (mem_a_in[1:0] == 2'b00) begin
                        r_snap        <= r_cnt;
                        mem_rdata_out <= r_cnt[7:0];
                    end else begin
                        mem_rdata_out <= w_snap_byte;
                    end
                end
                default:  mem_rdata_out <= 8'h00;
            endcase
        end
    end

    // Free-running cycle counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt <= 32'h0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Sticky status flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            program_stop <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            if (w_stop_wr) begin
                program_stop <= 1'b1;
            end
            if (w_tx_drop) begin
                tx_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_io_responder
// Description : Scoreboard bench for mem_io_responder with a queue-based
//               reference model, directed scenarios and a random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

    logic        clk_in       = 1'b0;
    logic        rst_in       = 1'b1;
    logic [31:0] mem_a_in     = 32'h0;
    logic [7:0]  mem_wdata_in = 8'h00;
    logic        mem_wr_in    = 1'b0;
    logic        tx_ready     = 1'b0;
    logic [7:0]  rx_data      = 8'h00;
    logic        rx_valid     = 1'b0;
    logic [7:0]  mem_rdata_out;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        rx_full;
    logic        program_stop;
    logic        tx_overflow;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .mem_a_in       (mem_a_in),
        .mem_wdata_in   (mem_wdata_in),
        .mem_wr_in      (mem_wr_in),
        .mem_rdata_out  (mem_rdata_out),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_full        (rx_full),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  m_ram [int];
    logic [7:0]  exp_rd_q [$];
    logic [7:0]  exp_tx_q [$];
    logic [7:0]  m_rx_q [$];
    int          m_tx_occ = 0;
    logic [31:0] m_cnt    = 0;
    logic [31:0] m_snap   = 0;
    logic        m_stop   = 0;
    logic        m_ovf    = 0;
    bit          m_started = 0;

    logic [17:0] a18;
    logic [7:0]  e;
    bit          is_io, tx_pop, rx_popped, rx_was_full;
    int          tx_push_n;

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: applies the bus/FIFO rules to plain queues at each edge.
    always @(posedge clk_in) begin
        m_started = 1;
        if (rst_in) begin
            exp_tx_q.delete();
            m_rx_q.delete();
            m_tx_occ = 0;
            m_cnt    = 0;
            m_snap   = 0;
            m_stop   = 0;
            m_ovf    = 0;
            exp_rd_q.delete();
            exp_rd_q.push_back(8'h00);
        end else begin
            a18         = mem_a_in[17:0];
            is_io       = (a18[17:16] == 2'b11);
            tx_pop      = tx_ready && (m_tx_occ > 0);
            tx_push_n   = 0;
            rx_popped   = 0;
            rx_was_full = (m_rx_q.size() == 8);
            if (mem_wr_in) begin
                if (!is_io) begin
                    m_ram[int'(a18 & 18'h1FFFF)] = mem_wdata_in;
                end else if (a18 == 18'h30000 || a18 == 18'h30004) begin
                    if (a18 == 18'h30004) m_stop = 1;
                    if (a18 == 18'h30004 || mem_wdata_in != 8'h00) begin
                        if (m_tx_occ < 8 || tx_pop) begin
                            exp_tx_q.push_back(a18 == 18'h30004 ? 8'h00 : mem_wdata_in);
                            tx_push_n = 1;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end
            end else begin
                if (!is_io) begin
                    e = m_ram[int'(a18 & 18'h1FFFF)];
                end else if (a18 == 18'h30000) begin
                    if (m_rx_q.size() > 0) begin
                        e = m_rx_q.pop_front();
                        rx_popped = 1;
                    end else begin
                        e = 8'h00;
                    end
                end else if (a18 >= 18'h30004 && a18 <= 18'h30007) begin
                    if (a18 == 18'h30004) m_snap = m_cnt;
                    e = 8'(m_snap >> (8 * a18[1:0]));
                end else begin
                    e = 8'h00;
                end
                exp_rd_q.push_back(e);
            end
            if (rx_valid && (!rx_was_full || rx_popped)) m_rx_q.push_back(rx_data);
            m_tx_occ = m_tx_occ + tx_push_n - (tx_pop ? 1 : 0);
            m_cnt    = m_cnt + 32'd1;
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk_in) begin
        if (m_started) begin
            if (exp_rd_q.size() > 0) check8("rdata", mem_rdata_out, exp_rd_q.pop_front());
            check1("tx_valid", tx_valid, m_tx_occ > 0);
            check1("io_buffer_full", io_buffer_full, m_tx_occ >= 6);
            check1("rx_full", rx_full, m_rx_q.size() == 8);
            check1("program_stop", program_stop, m_stop);
            check1("tx_overflow", tx_overflow, m_ovf);
            if (!rst_in && tx_ready && tx_valid) begin
                if (exp_tx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_data: got %02h expected no byte at %0t", tx_data, $time);
                end else begin
                    check8("tx_data", tx_data, exp_tx_q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic [31:0] a, input logic [7:0] d, input logic wr);
        mem_a_in     = a;
        mem_wdata_in = d;
        mem_wr_in    = wr;
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        step(a, d, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a);
        step(a, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rd(32'h0000_0123);
    endtask

    task automatic do_reset(input int n);
        rst_in = 1'b1;
        for (int i = 0; i < n; i++) step(32'h0, 8'h00, 1'b0);
        rst_in = 1'b0;
    endtask

    logic [31:0] pool [16];
    logic [31:0] r;
    int          op;

    initial begin
        do_reset(3);

        // RAM pool, including aliases that differ only in ignored/decoded-away bits
        pool[0] = 32'h0000_0123;
        pool[1] = 32'h0001_FFFF;
        pool[2] = 32'hABC0_0123;
        pool[3] = 32'h0002_0123;
        for (int i = 4; i < 16; i++) begin
            r = $urandom();
            if (r[17:16] == 2'b11) r[17] = 1'b0;
            pool[i] = r;
        end
        for (int i = 0; i < 16; i++) wr(pool[i], 8'($urandom()));
        wr(32'h0001_FFFF, 8'h3C);
        wr(32'h0000_0123, 8'hA5);
        rd(32'h0000_0123);
        rd(32'h0001_FFFF);
        wr(32'h0000_0123, 8'h5A);
        rd(32'h0000_0123);

        // TX: zero bytes are skipped, then drain in order
        tx_ready = 1'b0;
        wr(32'h0003_0000, 8'h41);
        wr(32'h0003_0000, 8'h00);
        wr(32'h0003_0000, 8'h42);
        idle(2);
        tx_ready = 1'b1;
        idle(4);

        // TX fill to overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(32'h0003_0000, 8'(8'h61 + i));
        idle(2);
        tx_ready = 1'b1;
        idle(10);

        // RX: empty read, two bytes, then overfill
        rd(32'h0003_0000);
        rx_data = 8'h10; rx_valid = 1'b1; idle(1);
        rx_data = 8'h20; rx_valid = 1'b1; idle(1);
        rd(32'h0003_0000);
        rd(32'h0003_0000);
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'(8'h80 + i); rx_valid = 1'b1; idle(1);
        end
        for (int i = 0; i < 9; i++) rd(32'h0003_0000);

        // Cycle counter snapshot after 100 cycles
        do_reset(1);
        idle(100);
        rd(32'h0003_0004);
        rd(32'h0003_0005);
        rd(32'h0003_0006);
        rd(32'h0003_0007);

        // Stop port, then reset mid-sequence
        tx_ready = 1'b0;
        wr(32'h0003_0004, 8'hFF);
        wr(32'h0003_0000, 8'h77);
        rx_data = 8'h33; rx_valid = 1'b1; idle(1);
        do_reset(1);
        idle(2);

        // Random phase
        for (int i = 0; i < 800; i++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                rx_data  = 8'($urandom());
                rx_valid = 1'b1;
            end
            r  = $urandom();
            op = $urandom_range(0, 99);
            if (op < 22)      wr(pool[$urandom_range(0, 15)], 8'($urandom()));
            else if (op < 44) rd(pool[$urandom_range(0, 15)]);
            else if (op < 58) wr({r[31:18], 18'h30000}, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom()));
            else if (op < 72) rd({r[31:18], 18'h30000});
            else if (op < 84) rd({r[31:18], 16'h0000, 2'($urandom_range(0, 3))} | 32'h0003_0004);
            else if (op < 88) rd({r[31:18], 18'h30008} | {14'h0, 2'b00, r[15:0]});
            else if (op < 92) wr({r[31:18], 18'h30001} | {14'h0, 2'b00, r[15:2], 2'b00}, 8'($urandom()));
            else if (op < 93) wr(32'h0003_0005, 8'($urandom()));
            else if (op < 94) wr(32'h0003_0004, 8'($urandom()));
            else if (op < 95) do_reset(1);
            else              idle(1);
        end
        tx_ready = 1'b1;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
